// File: rtl/control_register_bank.sv
// control_register_bank
//   Avalon-MM slave register bank for the pattern-search datapath.
//   The CPU writes shadow pattern words. A COMMIT strobe copies all of them
//   to pattern_o in one edge, so the matcher never sees a half-updated key.
//
// Ports
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   amm_*                    Avalon-MM slave (word addressed, fixed 1-cycle reads,
//                            never stalls)
//   match_i                  one-cycle match pulse from the matcher
//   pattern_o                committed pattern words
//   wrken_o                  CTRL.EN
//   commit_o                 high for the single cycle in which pattern_o was updated
//   irq_o                    STATUS.MATCH & CTRL.IRQ_EN
//
// Register map (word addresses)
//   0 CTRL      [0] EN, [1] COMMIT (write-1 strobe, reads 0), [2] IRQ_EN
//   1 STATUS    [0] MATCH (sticky, W1C), [1] PENDING (RO)
//   2 MATCH_CNT saturating count; any write with a byte lane enabled clears it
//   3.. SHADOW[k]
module control_register_bank #(
    parameter int                DATA_W    = 32,
    parameter int                PAT_REGS  = 3,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] PAT_RESET = '1,
    parameter int                ADDR_W    = $clog2(PAT_REGS + 3)
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic [ADDR_W-1:0]                amm_address_i,
    input  logic                             amm_write_i,
    input  logic [DATA_W-1:0]                amm_writedata_i,
    input  logic [DATA_W/8-1:0]              amm_byteenable_i,
    input  logic                             amm_read_i,
    output logic [DATA_W-1:0]                amm_readdata_o,
    output logic                             amm_readdatavalid_o,
    output logic                             amm_waitrequest_o,
    input  logic                             match_i,
    output logic [PAT_REGS-1:0][DATA_W-1:0]  pattern_o,
    output logic                             wrken_o,
    output logic                             commit_o,
    output logic                             irq_o
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CNT    = ADDR_W'(2);

    logic                            en;
    logic                            irq_en;
    logic                            match_flag;
    logic                            pending;
    logic                            commit_req;
    logic [CNT_W-1:0]                cnt;
    logic [PAT_REGS-1:0][DATA_W-1:0] shadow;

    logic [PAT_REGS-1:0] shadow_sel;
    logic [DATA_W-1:0]   wmask;
    logic [DATA_W-1:0]   rd_val;
    logic                any_be;
    logic                wr_ctrl;
    logic                wr_status;
    logic                wr_cnt;
    logic                wr_shadow;

    assign amm_waitrequest_o = 1'b0;
    assign wrken_o           = en;
    assign irq_o             = match_flag & irq_en;

    assign any_be    = |amm_byteenable_i;
    assign wr_ctrl   = amm_write_i && (amm_address_i == A_CTRL);
    assign wr_status = amm_write_i && (amm_address_i == A_STATUS);
    assign wr_cnt    = amm_write_i && (amm_address_i == A_CNT);
    assign wr_shadow = amm_write_i && (|shadow_sel) && any_be;

    always_comb begin
        shadow_sel = '0;
        for (int k = 0; k < PAT_REGS; k++)
            shadow_sel[k] = (int'(amm_address_i) == 3 + k);
    end

    always_comb begin
        wmask = '0;
        for (int b = 0; b < BE_W; b++)
            wmask[8*b +: 8] = {8{amm_byteenable_i[b]}};
    end

    // Read mux sees the registers before this cycle's write lands, so a
    // same-address read/write returns the old value.
    always_comb begin
        rd_val = '0;
        case (amm_address_i)
            A_CTRL: begin
                rd_val[0] = en;
                rd_val[2] = irq_en;
            end
            A_STATUS: rd_val[1:0] = {pending, match_flag};
            A_CNT:    rd_val[CNT_W-1:0] = cnt;
            default: begin
                for (int k = 0; k < PAT_REGS; k++)
                    if (shadow_sel[k]) rd_val = shadow[k];
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            amm_readdata_o      <= '0;
            amm_readdatavalid_o <= 1'b0;
        end else begin
            amm_readdatavalid_o <= amm_read_i;
            if (amm_read_i) amm_readdata_o <= rd_val;
        end
    end

    // Control and status
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            en         <= 1'b0;
            irq_en     <= 1'b0;
            commit_req <= 1'b0;
            match_flag <= 1'b0;
            cnt        <= '0;
        end else begin
            commit_req <= 1'b0;
            if (wr_ctrl && amm_byteenable_i[0]) begin
                en         <= amm_writedata_i[0];
                irq_en     <= amm_writedata_i[2];
                commit_req <= amm_writedata_i[1];
            end
            // A new match beats a simultaneous W1C.
            if (match_i)
                match_flag <= 1'b1;
            else if (wr_status && amm_byteenable_i[0] && amm_writedata_i[0])
                match_flag <= 1'b0;
            // A clear beats a simultaneous match; count saturates at all-ones.
            if (wr_cnt && any_be)
                cnt <= '0;
            else if (match_i && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

    // Shadow/active pattern words. The copy reads shadow before any write
    // sampled on the same edge, so a racing shadow write keeps PENDING set.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shadow    <= {PAT_REGS{PAT_RESET}};
            pattern_o <= {PAT_REGS{PAT_RESET}};
            pending   <= 1'b0;
            commit_o  <= 1'b0;
        end else begin
            commit_o <= commit_req;
            if (commit_req) pattern_o <= shadow;
            for (int k = 0; k < PAT_REGS; k++)
                if (amm_write_i && shadow_sel[k])
                    shadow[k] <= (shadow[k] & ~wmask) | (amm_writedata_i & wmask);
            if (wr_shadow)
                pending <= 1'b1;
            else if (commit_req)
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_control_register_bank.sv
module tb_control_register_bank;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic [2:0]         addr = '0;
    logic               wr = 1'b0;
    logic [31:0]        wdata = '0;
    logic [3:0]         be = '0;
    logic               rd = 1'b0;
    logic [31:0]        rdata;
    logic               rvalid;
    logic               waitreq;
    logic               match = 1'b0;
    logic [2:0][31:0]   pat;
    logic               wrken;
    logic               commit;
    logic               irq;

    control_register_bank dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .amm_address_i       (addr),
        .amm_write_i         (wr),
        .amm_writedata_i     (wdata),
        .amm_byteenable_i    (be),
        .amm_read_i          (rd),
        .amm_readdata_o      (rdata),
        .amm_readdatavalid_o (rvalid),
        .amm_waitrequest_o   (waitreq),
        .match_i             (match),
        .pattern_o           (pat),
        .wrken_o             (wrken),
        .commit_o            (commit),
        .irq_o               (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } rd_exp_t;
    rd_exp_t q[$];

    // Reference model: register contents as the CPU sees them.
    bit          m_en, m_irqen, m_match, m_pend, m_cpend, m_commit;
    int unsigned m_cnt;
    logic [31:0] m_shadow [3];
    logic [31:0] m_active [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%08h expected=%08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_match = 0; m_pend = 0; m_cpend = 0; m_commit = 0;
        m_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            m_shadow[k] = 32'hFFFF_FFFF;
            m_active[k] = 32'hFFFF_FFFF;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {29'd0, m_irqen, 1'b0, m_en};
            3'd1: return {30'd0, m_pend, m_match};
            3'd2: return m_cnt;
            3'd3, 3'd4, 3'd5: return m_shadow[a - 3'd3];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit w, input logic [2:0] a, input logic [31:0] d,
                              input logic [3:0] b, input bit m);
        // Commit copies the shadow as it stood before this edge's write.
        m_commit = m_cpend;
        if (m_cpend) begin
            for (int k = 0; k < 3; k++) m_active[k] = m_shadow[k];
            m_pend = 0;
        end
        m_cpend = 0;
        if (w && a == 0 && b[0]) begin
            m_en = d[0]; m_irqen = d[2]; m_cpend = d[1];
        end
        if (w && a == 1 && b[0] && d[0]) m_match = 0;
        if (m) m_match = 1;
        if (w && a == 2 && b != 0) m_cnt = 0;
        else if (m && m_cnt < 65535) m_cnt++;
        if (w && a >= 3 && a <= 5) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) m_shadow[a - 3'd3][8*i +: 8] = d[8*i +: 8];
            if (b != 0) m_pend = 1;
        end
    endtask

    // One bus cycle, started and finished at a falling edge.
    task automatic step(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit r, input bit m, input bit rst_mid = 0);
        rd_exp_t e;
        arst_n = 1'b1;
        wr = w; addr = a; wdata = d; be = b; rd = r; match = m;
        if (r) begin
            e.d = model_read(a);
            e.c = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        model_edge(w, a, d, b, m);
        if (rst_mid) begin
            #1;
            arst_n = 1'b0;
            model_reset();
            q.delete();
        end
        @(negedge clk);
        wr = 0; rd = 0; match = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 32'd0, 4'd0, 0, 0);
    endtask

    // Monitor: compares every output against the model each falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit exp_v;
            automatic rd_exp_t e;
            while (q.size() > 0 && q[0].c < cyc) begin
                e = q.pop_front();
                chk("rd_missing", 32'd0, 32'd1);
            end
            exp_v = (q.size() > 0) && (q[0].c == cyc);
            chk("readdatavalid", {31'd0, rvalid}, {31'd0, exp_v});
            if (exp_v) begin
                e = q.pop_front();
                if (rvalid) chk("readdata", rdata, e.d);
            end
            for (int k = 0; k < 3; k++) chk($sformatf("pattern[%0d]", k), pat[k], m_active[k]);
            chk("commit", {31'd0, commit}, {31'd0, m_commit});
            chk("irq", {31'd0, irq}, {31'd0, m_match & m_irqen});
            chk("wrken", {31'd0, wrken}, {31'd0, m_en});
            chk("waitrequest", {31'd0, waitreq}, 32'd0);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        mon_en = 1'b1;

        // Reset values, back-to-back reads including an unmapped address.
        for (int a = 0; a < 6; a++) step(0, 3'(a), 32'd0, 4'd0, 1, 0);
        step(0, 3'd7, 32'd0, 4'd0, 1, 0);

        // Partial shadow write, pending, then commit.
        step(1, 3'd3, 32'h1122_3344, 4'b0101, 0, 0);
        step(0, 3'd3, 32'd0, 4'd0, 1, 0);
        step(0, 3'd1, 32'd0, 4'd0, 1, 0);
        step(1, 3'd0, 32'h3, 4'hF, 0, 0);
        idle(2);
        step(0, 3'd1, 32'd0, 4'd0, 1, 0);

        // Match flag, counter and interrupt.
        step(1, 3'd0, 32'h4, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 3'd0, 32'd0, 4'd0, 0, 1);
        step(0, 3'd2, 32'd0, 4'd0, 1, 0);
        step(0, 3'd1, 32'd0, 4'd0, 1, 0);
        step(1, 3'd1, 32'h1, 4'h1, 0, 0);
        step(0, 3'd0, 32'd0, 4'd0, 0, 1);
        step(1, 3'd1, 32'h1, 4'h1, 1, 1);
        step(0, 3'd1, 32'd0, 4'd0, 1, 0);

        // Counter saturation, then clear racing a match.
        step(1, 3'd2, 32'd0, 4'h2, 0, 0);
        for (int i = 0; i < 65535; i++) step(0, 3'd6, 32'd0, 4'd0, 0, 1);
        step(0, 3'd2, 32'd0, 4'd0, 1, 1);
        step(0, 3'd2, 32'd0, 4'd0, 1, 0);
        step(1, 3'd2, 32'd0, 4'h8, 0, 1);
        step(0, 3'd2, 32'd0, 4'd0, 1, 0);

        // Same-cycle read and write of SHADOW[1].
        step(1, 3'd4, 32'hA5A5_A5A5, 4'hF, 1, 0);
        step(0, 3'd4, 32'd0, 4'd0, 1, 0);

        // Shadow write on the commit-copy edge: old value committed, pending stays.
        step(1, 3'd0, 32'h2, 4'h1, 0, 0);
        step(1, 3'd5, 32'h0BAD_F00D, 4'hF, 0, 0);
        step(0, 3'd1, 32'd0, 4'd0, 1, 0);
        step(0, 3'd5, 32'd0, 4'd0, 1, 0);

        // Reset with a read in flight, and reset right after a commit write.
        step(0, 3'd4, 32'd0, 4'd0, 1, 0, 1);
        idle(2);
        step(1, 3'd3, 32'h1234_5678, 4'hF, 0, 0);
        step(1, 3'd0, 32'h3, 4'h1, 0, 0, 1);
        idle(3);
        step(0, 3'd3, 32'd0, 4'd0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            automatic logic [2:0] a = 3'($urandom_range(0, 7));
            step($urandom_range(0, 2) == 0, a, $urandom, 4'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        idle(3);
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
